// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared opcodes, frame lengths and state types for the UART command host
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR       = 8'hA3;
    localparam logic [7:0] CMD_RD       = 8'hA5;
    localparam int         WR_FRAME_LEN = 9;
    localparam int         RD_FRAME_LEN = 5;
    localparam int         RSP_LEN      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE
    } host_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // 8N1 character as shifted out LSB first: start(0), data, stop(1)
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/uart_cmd_host_if.sv
// rtl/uart_cmd_host_if.sv - request/response port bundle of the UART command host
interface uart_cmd_host_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/uart_host_rx.sv
// rtl/uart_host_rx.sv - response receiver: rx synchroniser, start validation, byte assembly
module uart_host_rx
    import uart_cmd_pkg::*;
#(
    parameter int BIT = 80
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       en,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       start_det
);

    localparam int CNT_W = $clog2(BIT);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rstate, rstate_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitn;
    logic [7:0]       shift;
    logic             fall, half, full;

    assign fall = rx_prev && !rx_sync;
    assign half = cnt == CNT_W'(BIT / 2 - 1);
    assign full = cnt == CNT_W'(BIT - 1);

    // next receiver state; disabling the receiver throws away any partial character
    always_comb begin
        rstate_nxt = rstate;
        if (!en) begin
            rstate_nxt = RX_IDLE;
        end else begin
            case (rstate)
                RX_IDLE:  if (fall) rstate_nxt = RX_START;
                RX_START: if (half) rstate_nxt = rx_sync ? RX_IDLE : RX_DATA;
                RX_DATA:  if (full && bitn == 3'd7) rstate_nxt = RX_STOP;
                RX_STOP:  if (full) rstate_nxt = RX_IDLE;
                default:  rstate_nxt = RX_IDLE;
            endcase
        end
    end

    // synchroniser, bit timing, shift register and the sticky stop-bit error
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rstate     <= RX_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
            start_det  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rstate     <= rstate_nxt;
            byte_valid <= 1'b0;
            start_det  <= 1'b0;
            if (!en) begin
                cnt       <= '0;
                frame_err <= 1'b0;
            end else begin
                case (rstate)
                    RX_IDLE: cnt <= '0;
                    RX_START: begin
                        if (half) begin
                            cnt       <= '0;
                            bitn      <= '0;
                            start_det <= !rx_sync;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (full) begin
                            cnt   <= '0;
                            shift <= {rx_sync, shift[7:1]};
                            bitn  <= bitn + 3'd1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RX_STOP: begin
                        if (full) begin
                            cnt        <= '0;
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                            frame_err  <= frame_err | !rx_sync;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - UART bridge command initiator: request port, TX framing, response FSM
module uart_cmd_host
    import uart_cmd_pkg::*;
#(
    parameter int PRESCALE     = 4,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic           HCLK,
    input  logic           HRESET,
    uart_cmd_host_if.slave bus,
    output logic           busy,
    output logic           tx,
    input  logic           rx
);

    localparam int BIT   = 16 * (PRESCALE + 1);
    localparam int BIT_W = $clog2(BIT);
    localparam int TMO   = TIMEOUT_BITS * BIT;
    localparam int TMO_W = $clog2(TMO + 1);

    host_state_t      state, state_nxt;
    logic             is_write;
    logic [31:0]      addr_q, wdata_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx, byte_idx, next_idx;
    logic [9:0]       tx_shift;
    logic [7:0]       next_byte;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       rsp_idx;
    logic [31:0]      rdata_buf, rdata_q;
    logic             err_q;
    logic             rx_en, rx_byte_valid, rx_frame_err, rx_start_det;
    logic [7:0]       rx_byte;
    logic             accept, bit_end, byte_end, last_byte, rsp_last, timeout;

    assign accept    = (state == ST_IDLE) && bus.req_valid;
    assign bit_end   = bit_cnt == BIT_W'(BIT - 1);
    assign byte_end  = bit_end && (bit_idx == 4'd9);
    assign last_byte = byte_idx == (is_write ? 4'(WR_FRAME_LEN - 1) : 4'(RD_FRAME_LEN - 1));
    assign rsp_last  = rx_byte_valid && (rsp_idx == 2'(RSP_LEN - 1));
    // a start detected on the same cycle restarts the window instead of expiring it
    assign timeout   = (tmo_cnt == TMO_W'(TMO - 1)) && !rx_start_det;
    assign rx_en     = state == ST_RECV;

    assign tx            = tx_shift[0];
    assign busy          = state != ST_IDLE;
    assign bus.req_ready = state == ST_IDLE;
    assign bus.rsp_valid = state == ST_DONE;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    uart_host_rx #(
        .BIT(BIT)
    ) u_rx (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .en         (rx_en),
        .rx         (rx),
        .byte_valid (rx_byte_valid),
        .byte_data  (rx_byte),
        .frame_err  (rx_frame_err),
        .start_det  (rx_start_det)
    );

    // pick the frame byte that follows the one currently on the wire
    always_comb begin
        next_idx  = byte_idx + 4'd1;
        next_byte = is_write ? CMD_WR : CMD_RD;
        case (next_idx)
            4'd1:    next_byte = addr_q[7:0];
            4'd2:    next_byte = addr_q[15:8];
            4'd3:    next_byte = addr_q[23:16];
            4'd4:    next_byte = addr_q[31:24];
            4'd5:    next_byte = wdata_q[7:0];
            4'd6:    next_byte = wdata_q[15:8];
            4'd7:    next_byte = wdata_q[23:16];
            4'd8:    next_byte = wdata_q[31:24];
            default: ;
        endcase
    end

    // transaction sequencing: send the command frame, collect the reply, report once
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SEND;
            ST_SEND: if (byte_end && last_byte) state_nxt = is_write ? ST_DONE : ST_RECV;
            ST_RECV: if (rsp_last || timeout) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state register plus request capture, TX shifter, timeout window and read data assembly
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            is_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            tx_shift  <= '1;
            tmo_cnt   <= '0;
            rsp_idx   <= '0;
            rdata_buf <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_write <= bus.req_write;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        tx_shift <= frame_bits(bus.req_write ? CMD_WR : CMD_RD);
                    end
                end
                ST_SEND: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx  <= '0;
                            byte_idx <= next_idx;
                            tx_shift <= last_byte ? 10'h3FF : frame_bits(next_byte);
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            tx_shift <= {1'b1, tx_shift[9:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    if (byte_end && last_byte) begin
                        tmo_cnt   <= '0;
                        rsp_idx   <= '0;
                        rdata_buf <= '0;
                        if (is_write) begin
                            rdata_q <= '0;
                            err_q   <= 1'b0;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_start_det) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != TMO_W'(TMO)) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                    if (rx_byte_valid) begin
                        rdata_buf[{rsp_idx, 3'b000} +: 8] <= rx_byte;
                        rsp_idx                           <= rsp_idx + 2'd1;
                    end
                    if (rsp_last) begin
                        rdata_q <= rx_frame_err ? 32'h0 : {rx_byte, rdata_buf[23:0]};
                        err_q   <= rx_frame_err;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// tb/tb_uart_cmd_host.sv - directed self-checking bench for uart_cmd_host
module tb_uart_cmd_host;

    localparam int PRESCALE     = 4;
    localparam int TIMEOUT_BITS = 64;
    localparam int BIT          = 16 * (PRESCALE + 1);
    localparam int TMO          = TIMEOUT_BITS * BIT;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        rx     = 1'b1;
    logic        busy, tx;

    int          tests   = 0;
    int          fails   = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          rsp_cnt = 0;
    int          cap_cyc = 0;
    logic [31:0] cap_rdata = '0;
    logic        cap_err   = 1'b0;
    logic        cap_ready = 1'b0;

    uart_cmd_host_if bus ();

    uart_cmd_host #(
        .PRESCALE     (PRESCALE),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus),
        .busy   (busy),
        .tx     (tx),
        .rx     (rx)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_cnt   <= rsp_cnt + 1;
            cap_cyc   <= cyc;
            cap_rdata <= bus.rsp_rdata;
            cap_err   <= bus.rsp_err;
            cap_ready <= bus.req_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        acc_cyc = cyc;
        tick(1);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        check("tx_first_drop", 32'(tx), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic get_tx_byte(output logic [7:0] b);
        int n;
        n = 0;
        b = '0;
        while (tx !== 1'b0 && n < 2 * BIT) begin
            tick(1);
            n++;
        end
        check("tx_start_found", 32'(tx), 32'd0);
        tick(BIT / 2);
        for (int i = 0; i < 8; i++) begin
            tick(BIT);
            b[i] = tx;
        end
        tick(BIT);
        check("tx_stop_bit", 32'(tx), 32'd1);
    endtask

    task automatic check_frame(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] exp_b [9];
        logic [7:0] b;
        int         len;
        exp_b[0] = wr ? 8'hA3 : 8'hA5;
        for (int i = 0; i < 4; i++) begin
            exp_b[1 + i] = a[8 * i +: 8];
            exp_b[5 + i] = d[8 * i +: 8];
        end
        len = wr ? 9 : 5;
        for (int i = 0; i < len; i++) begin
            get_tx_byte(b);
            check($sformatf("tx_byte%0d", i), 32'(b), 32'(exp_b[i]));
        end
    endtask

    task automatic send_rx_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop_v;
        tick(BIT);
        rx = 1'b1;
        tick(BIT);
    endtask

    task automatic wait_rsp(input int base, input int limit);
        int n;
        n = 0;
        while (rsp_cnt == base && n < limit) begin
            tick(1);
            n++;
        end
        check("rsp_seen", 32'(rsp_cnt), 32'(base + 1));
        check("ready_low_in_done", 32'(cap_ready), 32'd0);
        tick(3);
        check("rsp_single_pulse", 32'(rsp_cnt), 32'(base + 1));
        check("ready_after_done", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int         base;
        int         hi;
        logic [7:0] b;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        HRESET = 1'b1;
        tick(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        HRESET = 1'b0;
        tick(2);

        base = rsp_cnt;
        request(1'b1, 32'h0000_0018, 32'hA5A8_5501);
        check_frame(1'b1, 32'h0000_0018, 32'hA5A8_5501);
        wait_rsp(base, 2 * BIT);
        check("wr_latency", 32'(cap_cyc - acc_cyc), 32'(90 * BIT + 1));
        check("wr_err", 32'(cap_err), 32'd0);
        check("wr_rdata", cap_rdata, 32'h0);

        base = rsp_cnt;
        request(1'b0, 32'h0000_0014, 32'h0);
        check_frame(1'b0, 32'h0000_0014, 32'h0);
        tick(BIT / 2 + 2 * BIT);
        send_rx_byte(8'h78, 1'b1);
        send_rx_byte(8'h56, 1'b1);
        send_rx_byte(8'h34, 1'b1);
        send_rx_byte(8'h12, 1'b1);
        wait_rsp(base, 4 * BIT);
        check("rd_rdata", cap_rdata, 32'h1234_5678);
        check("rd_err", 32'(cap_err), 32'd0);

        base = rsp_cnt;
        request(1'b0, 32'h0000_0030, 32'h0);
        check_frame(1'b0, 32'h0000_0030, 32'h0);
        tick(BIT / 2 + 2 * BIT);
        send_rx_byte(8'h11, 1'b1);
        send_rx_byte(8'h22, 1'b1);
        send_rx_byte(8'h33, 1'b0);
        send_rx_byte(8'h44, 1'b1);
        wait_rsp(base, 4 * BIT);
        check("ferr_err", 32'(cap_err), 32'd1);
        check("ferr_rdata", cap_rdata, 32'h0);

        base = rsp_cnt;
        request(1'b0, 32'h0000_0020, 32'h0);
        check_frame(1'b0, 32'h0000_0020, 32'h0);
        wait_rsp(base, TMO + 2 * BIT);
        check("tmo_latency", 32'(cap_cyc - acc_cyc), 32'(50 * BIT + TMO + 1));
        check("tmo_err", 32'(cap_err), 32'd1);
        check("tmo_rdata", cap_rdata, 32'h0);

        base = rsp_cnt;
        request(1'b0, 32'h0000_0044, 32'h0);
        check_frame(1'b0, 32'h0000_0044, 32'h0);
        tick(BIT / 2 + BIT);
        rx = 1'b0;
        tick(BIT / 4);
        rx = 1'b1;
        tick(2 * BIT);
        send_rx_byte(8'hEF, 1'b1);
        send_rx_byte(8'hBE, 1'b1);
        send_rx_byte(8'hAD, 1'b1);
        send_rx_byte(8'hDE, 1'b1);
        wait_rsp(base, 4 * BIT);
        check("glitch_rdata", cap_rdata, 32'hDEAD_BEEF);
        check("glitch_err", 32'(cap_err), 32'd0);

        base = rsp_cnt;
        request(1'b1, 32'h0000_0040, 32'h1234_ABCD);
        get_tx_byte(b);
        check("rst_wr_byte0", 32'(b), 32'hA3);
        get_tx_byte(b);
        check("rst_wr_byte1", 32'(b), 32'h40);
        hi = 0;
        while (tx !== 1'b0 && hi < 2 * BIT) begin
            tick(1);
            hi++;
        end
        tick(BIT / 2 + 3 * BIT);
        HRESET = 1'b1;
        tick(1);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        HRESET = 1'b0;
        hi = 0;
        for (int i = 0; i < 2 * BIT; i++) begin
            tick(1);
            if (tx === 1'b1) hi++;
        end
        check("midrst_tx_idle", 32'(hi), 32'(2 * BIT));
        check("midrst_no_rsp", 32'(rsp_cnt), 32'(base));

        base = rsp_cnt;
        request(1'b1, 32'h0000_0100, 32'hCAFE_F00D);
        check_frame(1'b1, 32'h0000_0100, 32'hCAFE_F00D);
        wait_rsp(base, 2 * BIT);
        check("post_rst_latency", 32'(cap_cyc - acc_cyc), 32'(90 * BIT + 1));
        check("post_rst_err", 32'(cap_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
